// File: rtl/scad_unit_if.sv
// SCAD unit bus: AR/CRAM inputs, load and loop controls, SCAD/FE/SC results.
// master drives controls and reads results; slave is the SCAD unit side.
// Define SCAD_DIAG_EN to add diag_sel/diag_read inputs and the ebus output.
interface scad_unit_if #(
    parameter int W = 10
);
    logic [0:35]  ar;
    logic [0:8]   magic;
    logic [2:0]   scad_op;
    logic [1:0]   scada_sel;
    logic [1:0]   scadb_sel;
    logic         fe_load;
    logic         sc_load;
    logic         loop_start;
    logic         loop_abort;
    logic [W-1:0] scad;
    logic [W-1:0] fe;
    logic [W-1:0] sc;
    logic         scad_sign;
    logic         sc_ge;
    logic         loop_busy;
    logic         loop_done;
    logic [W-1:0] loop_count;
`ifdef SCAD_DIAG_EN
    logic [4:6]   diag_sel;
    logic         diag_read;
    logic [0:35]  ebus;

    modport master (
        output ar, magic, scad_op, scada_sel, scadb_sel,
        output fe_load, sc_load, loop_start, loop_abort,
        output diag_sel, diag_read,
        input  scad, fe, sc, scad_sign, sc_ge,
        input  loop_busy, loop_done, loop_count, ebus
    );
    modport slave (
        input  ar, magic, scad_op, scada_sel, scadb_sel,
        input  fe_load, sc_load, loop_start, loop_abort,
        input  diag_sel, diag_read,
        output scad, fe, sc, scad_sign, sc_ge,
        output loop_busy, loop_done, loop_count, ebus
    );
`else
    modport master (
        output ar, magic, scad_op, scada_sel, scadb_sel,
        output fe_load, sc_load, loop_start, loop_abort,
        input  scad, fe, sc, scad_sign, sc_ge,
        input  loop_busy, loop_done, loop_count
    );
    modport slave (
        input  ar, magic, scad_op, scada_sel, scadb_sel,
        input  fe_load, sc_load, loop_start, loop_abort,
        output scad, fe, sc, scad_sign, sc_ge,
        output loop_busy, loop_done, loop_count
    );
`endif
endinterface

// File: rtl/scad_unit.sv
// KL10 shift-count adder with FE/SC registers and SC count-down loop.
// Ports: clk, rst_n (async low), bus (scad_unit_if.slave); SCAD_DIAG_EN adds ebus.
module scad_unit #(
    parameter int W         = 10,
    parameter int GE_THRESH = 36,
    parameter int LOOP_MAX  = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    scad_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic signed [W-1:0] GE_T = W'(GE_THRESH);
    localparam logic [W-1:0]        LMAX = W'(LOOP_MAX);
    localparam logic [W-1:0]        ONE  = W'(1);

    state_t       state;
    logic [W-1:0] a, b, scad;
    logic [W-1:0] fe, sc, cnt;
    logic [W-1:0] sc_dec, cnt_inc;
    logic         sc_ge, busy, done;
    logic         pend, start_req;
    logic         unused_ar;

    assign unused_ar = ^bus.ar[12:35];

    always_comb begin
        a = '0;
        unique case (bus.scada_sel)
            2'd0: a = fe;
            2'd1: a = W'(bus.ar[0:5]);
            // EXP field: ones-complement of the exponent when AR is negative
            2'd2: a = W'(bus.ar[1:8] ^ {8{bus.ar[0]}});
            2'd3: a = W'($signed(bus.magic));
        endcase
    end

    always_comb begin
        b = '0;
        unique case (bus.scadb_sel)
            2'd0: b = sc;
            2'd1: b = W'(bus.ar[6:11]);
            2'd2: b = W'(bus.ar[0:8]);
            2'd3: b = W'($signed(bus.magic));
        endcase
    end

    always_comb begin
        scad = '0;
        unique case (bus.scad_op)
            3'd0: scad = a;
            3'd1: scad = a + ~b;
            3'd2: scad = a + b;
            3'd3: scad = a - ONE;
            3'd4: scad = a + ONE;
            3'd5: scad = a - b;
            3'd6: scad = a | b;
            3'd7: scad = a & b;
        endcase
    end

    assign sc_dec    = sc - ONE;
    assign cnt_inc   = cnt + ONE;
    // a start that collided with sc_load is replayed the next cycle
    assign start_req = bus.loop_start | pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fe    <= '0;
            sc    <= '0;
            cnt   <= '0;
            sc_ge <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pend  <= 1'b0;
        end else begin
            done  <= 1'b0;
            sc_ge <= ($signed(sc) >= GE_T);
            if (bus.fe_load) fe <= scad;
            unique case (state)
                IDLE: begin
                    if (bus.sc_load) begin
                        sc   <= scad;
                        pend <= start_req;
                    end else begin
                        pend <= 1'b0;
                        if (start_req) begin
                            cnt <= '0;
                            if (sc[W-1]) begin
                                state <= DONE;
                            end else begin
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (bus.loop_abort) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        sc  <= sc_dec;
                        cnt <= cnt_inc;
                        if (sc_dec[W-1] || cnt_inc == LMAX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    pend  <= 1'b0;
                    state <= IDLE;
                    if (bus.sc_load) sc <= scad;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.scad       = scad;
    assign bus.fe         = fe;
    assign bus.sc         = sc;
    assign bus.scad_sign  = scad[W-1];
    assign bus.sc_ge      = sc_ge;
    assign bus.loop_busy  = busy;
    assign bus.loop_done  = done;
    assign bus.loop_count = cnt;

`ifdef SCAD_DIAG_EN
    always_comb begin
        bus.ebus = '0;
        if (bus.diag_read) begin
            unique case (bus.diag_sel)
                3'd0:    bus.ebus = 36'({fe, sc});
                3'd1:    bus.ebus = 36'(scad);
                3'd2:    bus.ebus = 36'({cnt, busy, sc_ge});
                default: bus.ebus = '0;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_scad_unit.sv
// Randomized bench for scad_unit against a behavioural model.
// Directed literal checks cover ops, EXP field, loop, abort and sc_ge.
module tb_scad_unit;
    localparam int W    = 10;
    localparam int GE   = 36;
    localparam int LMAX = 1023;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmp_en = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scad_unit_if #(.W(W)) bus();

    scad_unit #(.W(W), .GE_THRESH(GE), .LOOP_MAX(LMAX)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) t=%0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic int sx(int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    // model state
    int m_fe, m_sc, m_cnt, m_ge, m_busy, m_done;
    int m_pend, m_left, m_tail;

    function automatic int magic_val();
        return bus.magic[0] ? int'(bus.magic) - 512 : int'(bus.magic);
    endfunction

    function automatic int model_scad();
        int a, b, r;
        case (bus.scada_sel)
            2'd0: a = m_fe;
            2'd1: a = int'(bus.ar[0:5]);
            2'd2: a = bus.ar[0] ? 255 - int'(bus.ar[1:8]) : int'(bus.ar[1:8]);
            default: a = magic_val();
        endcase
        case (bus.scadb_sel)
            2'd0: b = m_sc;
            2'd1: b = int'(bus.ar[6:11]);
            2'd2: b = int'(bus.ar[0:8]);
            default: b = magic_val();
        endcase
        case (bus.scad_op)
            3'd0: r = a;
            3'd1: r = a - b - 1;
            3'd2: r = a + b;
            3'd3: r = a - 1;
            3'd4: r = a + 1;
            3'd5: r = a - b;
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r & MASK;
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        int s, ge_n, req;
        if (!rst_n) begin
            m_fe = 0; m_sc = 0; m_cnt = 0; m_ge = 0;
            m_busy = 0; m_done = 0; m_pend = 0;
            m_left = 0; m_tail = 0;
        end else begin
            s = model_scad();
            ge_n = (sx(m_sc) >= GE) ? 1 : 0;
            m_done = 0;
            if (bus.fe_load) m_fe = s;
            if (m_busy != 0) begin
                if (bus.loop_abort) begin
                    m_busy = 0; m_tail = 1;
                end else begin
                    m_sc = (m_sc - 1) & MASK;
                    m_cnt++;
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 0; m_tail = 1;
                    end
                end
            end else if (m_tail != 0) begin
                m_done = 1; m_tail = 0; m_pend = 0;
                if (bus.sc_load) m_sc = s;
            end else begin
                req = (bus.loop_start || m_pend != 0) ? 1 : 0;
                if (bus.sc_load) begin
                    m_sc = s; m_pend = req;
                end else begin
                    m_pend = 0;
                    if (req != 0) begin
                        m_cnt = 0;
                        if (sx(m_sc) < 0) begin
                            m_tail = 1;
                        end else begin
                            m_busy = 1;
                            m_left = (sx(m_sc) + 1 < LMAX) ? sx(m_sc) + 1 : LMAX;
                        end
                    end
                end
            end
            m_ge = ge_n;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("scad", bus.scad, model_scad());
            chk("scad_sign", bus.scad_sign, (model_scad() >> (W - 1)) & 1);
            chk("fe", bus.fe, m_fe);
            chk("sc", bus.sc, m_sc);
            chk("sc_ge", bus.sc_ge, m_ge);
            chk("loop_busy", bus.loop_busy, m_busy);
            chk("loop_done", bus.loop_done, m_done);
            chk("loop_count", bus.loop_count, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.ar = '0;
        bus.magic = '0;
        bus.scad_op = '0;
        bus.scada_sel = '0;
        bus.scadb_sel = '0;
        bus.fe_load = 1'b0;
        bus.sc_load = 1'b0;
        bus.loop_start = 1'b0;
        bus.loop_abort = 1'b0;
`ifdef SCAD_DIAG_EN
        bus.diag_sel = '0;
        bus.diag_read = 1'b0;
`endif
    endtask

    task automatic rand_inputs();
        logic [63:0] r;
        r = {$urandom, $urandom};
        bus.ar = r[35:0];
        bus.magic = 9'($urandom);
        bus.scad_op = 3'($urandom);
        bus.scada_sel = 2'($urandom);
        bus.scadb_sel = 2'($urandom);
        bus.fe_load = ($urandom_range(0, 3) == 0);
        bus.sc_load = ($urandom_range(0, 3) == 0);
        bus.loop_start = ($urandom_range(0, 7) == 0);
        bus.loop_abort = ($urandom_range(0, 39) == 0);
    endtask

    task automatic load_sc(int v);
        logic [31:0] t;
        t = v;
        bus.scada_sel = 2'd3;
        bus.scad_op = 3'd0;
        bus.magic = t[8:0];
        bus.sc_load = 1'b1;
        tick();
        bus.sc_load = 1'b0;
    endtask

    task automatic wait_done(int lim, string nm);
        for (int k = 0; k < lim && !bus.loop_done; k++) tick();
        chk(nm, bus.loop_done, 1);
    endtask

    initial begin
        int exp_ops[8];
        int nb, dk;
        exp_ops = '{5, 1, 8, 4, 6, 2, 7, 1};

        drive_idle();
        rst_n = 1'b0;
        #1;
        cmp_en = 1'b1;
        repeat (5) begin
            tick();
            rand_inputs();
        end
        #1;
        chk("rst_fe", bus.fe, 0);
        chk("rst_sc", bus.sc, 0);
        chk("rst_cnt", bus.loop_count, 0);
        chk("rst_busy", bus.loop_busy, 0);
        chk("rst_done", bus.loop_done, 0);
        chk("rst_ge", bus.sc_ge, 0);
        tick();
        drive_idle();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_fe", bus.fe, 0);
        chk("post_rst_sc", bus.sc, 0);

        // adder ops with FE=5, SC=3
        bus.scada_sel = 2'd3;
        bus.magic = 9'd5;
        bus.fe_load = 1'b1;
        tick();
        bus.fe_load = 1'b0;
        load_sc(3);
        bus.scada_sel = 2'd0;
        bus.scadb_sel = 2'd0;
        for (int op = 0; op < 8; op++) begin
            bus.scad_op = 3'(op);
            #1;
            chk($sformatf("op%0d", op), bus.scad, exp_ops[op]);
            tick();
        end

        // EXP field
        bus.scad_op = 3'd0;
        bus.scada_sel = 2'd2;
        bus.ar = 36'o400000000000;
        #1;
        chk("exp_neg", bus.scad, 255);
        bus.ar = 36'o200000000000;
        #1;
        chk("exp_pos", bus.scad, 128);
        tick();
        bus.ar = '0;

        // count-down loop from SC=3
        load_sc(3);
        bus.loop_start = 1'b1;
        tick();
        bus.loop_start = 1'b0;
        nb = 0;
        dk = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.loop_busy) nb++;
            if (bus.loop_done) begin
                dk = k;
                break;
            end
            tick();
        end
        chk("loop_busy_cycles", nb, 4);
        chk("loop_done_delay", dk, 5);
        chk("loop_sc_final", bus.sc, 10'h3FF);
        chk("loop_count_final", bus.loop_count, 4);
        tick();

        // abort plus ignored restart during busy
        load_sc(100);
        bus.loop_start = 1'b1;
        tick();
        bus.loop_start = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            if (j == 3) bus.loop_start = 1'b1;
            if (j == 6) bus.loop_start = 1'b0;
            tick();
        end
        bus.loop_abort = 1'b1;
        tick();
        bus.loop_abort = 1'b0;
        chk("abort_busy", bus.loop_busy, 0);
        chk("abort_sc", bus.sc, 91);
        chk("abort_count", bus.loop_count, 9);
        chk("abort_done_early", bus.loop_done, 0);
        tick();
        chk("abort_done", bus.loop_done, 1);
        tick();

        // sc_ge threshold
        load_sc(35);
        tick();
        chk("ge_35", bus.sc_ge, 0);
        load_sc(36);
        chk("ge_36_lag", bus.sc_ge, 0);
        tick();
        chk("ge_36", bus.sc_ge, 1);
        load_sc(-1);
        tick();
        chk("ge_m1", bus.sc_ge, 0);

        // negative SC: straight to done
        bus.loop_start = 1'b1;
        tick();
        bus.loop_start = 1'b0;
        chk("neg_busy", bus.loop_busy, 0);
        tick();
        chk("neg_done", bus.loop_done, 1);
        chk("neg_count", bus.loop_count, 0);
        tick();

        // sc_load and loop_start together
        bus.scada_sel = 2'd3;
        bus.magic = 9'd2;
        bus.sc_load = 1'b1;
        bus.loop_start = 1'b1;
        tick();
        bus.sc_load = 1'b0;
        bus.loop_start = 1'b0;
        chk("pend_idle", bus.loop_busy, 0);
        chk("pend_sc", bus.sc, 2);
        tick();
        chk("pend_busy", bus.loop_busy, 1);
        wait_done(10, "pend_done");
        chk("pend_count", bus.loop_count, 3);
        tick();

        // reset mid-loop
        load_sc(50);
        bus.loop_start = 1'b1;
        tick();
        bus.loop_start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.loop_busy, 0);
        chk("midrst_sc", bus.sc, 0);
        chk("midrst_cnt", bus.loop_count, 0);
        tick();
        chk("midrst_done", bus.loop_done, 0);
        rst_n = 1'b1;
        tick();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            rst_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst_n = 1'b1;
        drive_idle();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
